// File: rtl/intc_pkg.sv
// Shared constants for the interrupt controller: register offsets, IRQ state
// encoding and the claim ID width.
package intc_pkg;

  localparam logic [2:0] INTC_PENDING = 3'd0;
  localparam logic [2:0] INTC_ENABLE  = 3'd1;
  localparam logic [2:0] INTC_FIQSEL  = 3'd2;
  localparam logic [2:0] INTC_CLAIM   = 3'd3;
  localparam logic [2:0] INTC_EOI     = 3'd4;
  localparam logic [2:0] INTC_RAW     = 3'd5;

  localparam int INTC_ID_W = 5;

  typedef enum logic [1:0] {
    INTC_IDLE    = 2'd0,
    INTC_ASSERT  = 2'd1,
    INTC_SERVICE = 2'd2
  } intc_state_e;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-first priority encoder; returns index+1, or 0 when no request.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic [NSRC-1:0]      req_i,
  output logic [INTC_ID_W-1:0] id_o
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    id_o = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = INTC_ID_W'(i + 1);
    end
  end

endmodule

// File: rtl/intc.sv
// Memory-mapped interrupt controller: edge-latched pending bits, IRQ/FIQ
// classification, and a claim/EOI handshake for IRQ-class sources.
module intc
  import intc_pkg::*;
#(
  parameter int          NSRC = 8,
  parameter logic [31:0] BASE = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [31:0]     addr,
  input  logic            we,
  input  logic            re,
  input  logic [31:0]     write_data,
  output logic [31:0]     read_data,
  output logic            irq,
  output logic            firq
);

  logic [NSRC-1:0]      src_q;
  logic [NSRC-1:0]      pending_q, pending_d;
  logic [NSRC-1:0]      enable_q, fiqsel_q;
  logic [NSRC-1:0]      irq_elig, fiq_elig;
  logic [NSRC-1:0]      w1c_mask, claim_clr;
  logic [INTC_ID_W-1:0] top_id;
  logic [INTC_ID_W-1:0] active_id_q, active_id_d;
  intc_state_e          state_q, state_d;
  logic                 irq_q, firq_q;

  logic                 hit;
  logic [2:0]           sel;
  logic                 wr_hit, claim_rd, eoi_wr;
  logic                 unused_ok;

  assign hit       = (addr[31:5] == BASE[31:5]);
  assign sel       = addr[4:2];
  assign wr_hit    = we & hit;
  assign claim_rd  = re & hit & (sel == INTC_CLAIM);
  assign eoi_wr    = wr_hit & (sel == INTC_EOI);
  assign unused_ok = ^{addr[1:0], write_data};

  assign irq_elig = pending_q & enable_q & ~fiqsel_q;
  assign fiq_elig = pending_q & enable_q & fiqsel_q;

  intc_prio_enc #(.NSRC(NSRC)) u_prio_enc (
    .req_i (irq_elig),
    .id_o  (top_id)
  );

  always_comb begin
    read_data = '0;
    if (hit) begin
      case (sel)
        INTC_PENDING: read_data = 32'(pending_q);
        INTC_ENABLE:  read_data = 32'(enable_q);
        INTC_FIQSEL:  read_data = 32'(fiqsel_q);
        INTC_CLAIM:   if (state_q == INTC_ASSERT) read_data = 32'(top_id);
        INTC_RAW:     read_data = 32'(src);
        default:      read_data = '0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    claim_clr   = '0;
    case (state_q)
      INTC_IDLE: begin
        if (|irq_elig) state_d = INTC_ASSERT;
      end
      INTC_ASSERT: begin
        if (claim_rd) begin
          if (top_id != '0) begin
            claim_clr   = NSRC'(1) << (top_id - 1'b1);
            active_id_d = top_id;
            state_d     = INTC_SERVICE;
          end else begin
            state_d = INTC_IDLE;
          end
        end else if (!(|irq_elig)) begin
          state_d = INTC_IDLE;
        end
      end
      INTC_SERVICE: begin
        if (eoi_wr && (write_data[INTC_ID_W-1:0] == active_id_q)) state_d = INTC_IDLE;
      end
      default: state_d = INTC_IDLE;
    endcase
  end

  // A new edge wins over a clear (W1C or claim) of the same bit.
  assign w1c_mask  = (wr_hit && (sel == INTC_PENDING)) ? write_data[NSRC-1:0] : '0;
  assign pending_d = (pending_q & ~(w1c_mask | claim_clr)) | (src & ~src_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q       <= src;
      pending_q   <= '0;
      enable_q    <= '0;
      fiqsel_q    <= '0;
      active_id_q <= '0;
      state_q     <= INTC_IDLE;
      irq_q       <= 1'b0;
      firq_q      <= 1'b0;
    end else begin
      src_q       <= src;
      pending_q   <= pending_d;
      active_id_q <= active_id_d;
      state_q     <= state_d;
      irq_q       <= (state_d == INTC_ASSERT);
      firq_q      <= |fiq_elig;
      if (wr_hit && (sel == INTC_ENABLE)) enable_q <= write_data[NSRC-1:0];
      if (wr_hit && (sel == INTC_FIQSEL)) fiqsel_q <= write_data[NSRC-1:0];
    end
  end

  assign irq  = irq_q;
  assign firq = firq_q;

endmodule

// File: doc/intc.md
# intc

Interrupt controller for the single-cycle ARM-style core's `data_path`. It latches rising edges on up to `NSRC` peripheral interrupt lines and classifies each source as IRQ or FIQ. It drives the core's `irq` and `firq` inputs and runs a claim / end-of-interrupt (EOI) handshake for IRQ-class sources. It sits on the data-memory bus beside `dmem` as a memory-mapped slave; the core configures and acknowledges it with ordinary `ldr`/`str`.

## Interface
Parameters:
- `NSRC`, 8 — number of interrupt sources, 1..31.
- `BASE`, 32'h0000_0100 — base byte address, 32-byte aligned.

Ports:
- `clk` input 1 — the single clock; all state updates on rising edge.
- `reset` input 1 — synchronous, active-high.
- `src` input NSRC — interrupt request lines, synchronous to `clk`.
- `addr` input 32 — byte address from `data_path` (`addr_data`).
- `we` input 1 — write strobe from `data_path`.
- `re` input 1 — load strobe from the load decode; qualifies CLAIM side effects.
- `write_data` input 32 — store data.
- `read_data` output 32 — combinational register read, same cycle as `addr`, matching `dmem` read timing.
- `irq` output 1 — registered, to `data_path.irq`.
- `firq` output 1 — registered, to `data_path.firq`.

## Operation
- Address hit when `addr[31:5] == BASE[31:5]`; register select is `addr[4:2]`. A miss, or a reserved offset, reads 0 and ignores writes.
- Register map (word offsets):
  - 0x00 PENDING: read pending bits; write-1-to-clear.
  - 0x04 ENABLE: read/write.
  - 0x08 FIQSEL: read/write; 1 = the source is FIQ class.
  - 0x0C CLAIM: read-only.
  - 0x10 EOI: write-only.
  - 0x14 RAW: read returns `src` levels.
  - Only bits [NSRC-1:0] are implemented; the rest read 0.
- Edge detect: `src_q` holds last cycle's `src`. `pending[i]` is set when `src[i] & ~src_q[i]`. A set and a W1C of the same bit in the same cycle: set wins.
- Eligible vectors:
  - `irq_elig = pending & ENABLE & ~FIQSEL`
  - `fiq_elig = pending & ENABLE & FIQSEL`
- Priority: lowest index is highest priority. ID = index+1; 0 means none.
- `firq` next = `|fiq_elig`. FIQ sources are not claimed; software clears them through PENDING W1C.
- IRQ FSM:
  - IDLE: `irq`=0. If `|irq_elig`, go to ASSERT.
  - ASSERT: `irq`=1. A CLAIM read (`re` & hit & offset 0x0C) returns the current top ID. At the same edge it clears that pending bit, loads `active_id`, and goes to SERVICE. If the top ID is 0 (eligibility withdrawn by W1C/ENABLE write), go to IDLE. If no claim and `irq_elig` drops to 0, go to IDLE.
  - SERVICE: `irq`=0; no nesting. An EOI write with `write_data[4:0] == active_id` goes to IDLE. A non-matching EOI is ignored.
- CLAIM read outside ASSERT returns 0 with no side effect. CLAIM `read_data` is computed from current (pre-edge) state.
- Disabled sources still latch pending. Enabling a source later makes it eligible.

## Timing
- Reset values:
  - PENDING, ENABLE, FIQSEL = 0; `active_id` = 0; state IDLE.
  - `irq`, `firq` = 0.
  - `src_q` <= `src`, so no spurious edge at reset release.
- Latency:
  - `src` rises before edge k → `pending` set at edge k.
  - `firq` = 1 after edge k+1.
  - IRQ path: state ASSERT at edge k+1, `irq` = 1 after edge k+1 (2 edges from source edge to pin).
- `irq` falls after the claim edge. It can re-rise no earlier than 1 cycle after the EOI edge.
- Register writes take effect at the edge. `irq_elig`/`fiq_elig` use post-write values from the next cycle.
- Reset mid-service: everything returns to reset values; in-flight `active_id` is lost.

## Structure
- Package `intc_pkg`:
  - offset constants `INTC_PENDING`..`INTC_RAW`;
  - state encoding `INTC_IDLE`/`INTC_ASSERT`/`INTC_SERVICE` (2 bits);
  - ID width 5.
- Sub-module `intc_prio_enc`: combinational NSRC-to-ID lowest-index-first encoder, instanced for the CLAIM ID. `firq` needs only an OR.
- The testbench instantiates `intc` beside `dmem` and muxes `read_data` on address hit.

## Test plan
- Reset with `src`=8'h01 held → `irq`=`firq`=0 and PENDING=0 after release; no edge is latched.
- ENABLE=0x06, FIQSEL=0; pulse `src[2]` then `src[1]` → `irq`=1 two edges after the first pulse. CLAIM returns 2 (index 1 wins) and PENDING goes 0x06→0x04. EOI=2 → `irq` re-asserts; CLAIM returns 3.
- FIQSEL=0x80, ENABLE=0x80; pulse `src[7]` → `firq`=1 with `irq`=0. W1C PENDING=0x80 → `firq`=0 next cycle.
- In SERVICE: EOI=5 with `active_id`=2 → stays in SERVICE with `irq`=0. EOI=2 → IDLE.
- `src[0]` rising edge in the same cycle as a PENDING W1C of 0x01 → PENDING[0]=1.
- In ASSERT, clear ENABLE to 0 then CLAIM → returns 0, state goes to IDLE, `irq`=0; pending bit retained.
